// File: rtl/wrap_counter_pkg.sv
// Shared types and constants for the wrap counter bank: config FSM states,
// direction/mode encodings and default sizing.
package wrap_counter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } cfg_state_e;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int DEFAULT_WIDTH    = 10;
  localparam int DEFAULT_CHANNELS = 4;
  localparam int DEFAULT_LIMIT    = 500;

  // Channel-select width keeps one spare code so out-of-range targets can be expressed.
  function automatic int chan_sel_w(int channels);
    return $clog2(channels + 1);
  endfunction

endpackage

// File: rtl/wrap_counter_chan.sv
// One counter channel: up/down count with wrap or saturate at its limit,
// limit write with clamp, and a registered wrap/hold pulse.
module wrap_counter_chan
  import wrap_counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int RESET_LIMIT = DEFAULT_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_limit,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] limit,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] RST_LIMIT = WIDTH'(RESET_LIMIT);

  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] limit_nxt;
  logic             hit_nxt;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    count_nxt = count;
    limit_nxt = limit;
    hit_nxt   = 1'b0;
    if (wr_en) begin
      // A limit write owns the channel this cycle; en is ignored.
      limit_nxt = wr_limit;
      if (count > wr_limit) count_nxt = wr_limit;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (count < limit) begin
          count_nxt = count + 1'b1;
        end else begin
          hit_nxt = 1'b1;
          if (sat_mode == MODE_WRAP) count_nxt = (limit == '0) ? '0 : WIDTH'(1);
        end
      end else begin
        if (count != '0) begin
          count_nxt = count - 1'b1;
        end else begin
          hit_nxt = 1'b1;
          if (sat_mode == MODE_WRAP) count_nxt = limit;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all channels sample the same pre-edge values.
    if (rst) begin
      count      <= '0;
      limit      <= RST_LIMIT;
      wrap_pulse <= 1'b0;
    end else begin
      count      <= count_nxt;
      limit      <= limit_nxt;
      wrap_pulse <= hit_nxt;
    end
  end

endmodule

// File: rtl/wrap_counter_bank.sv
// Bank of independent wrap/saturate counters with a two-state limit-update
// controller and a sticky invariant-error flag.
module wrap_counter_bank #(
  parameter int WIDTH         = wrap_counter_pkg::DEFAULT_WIDTH,
  parameter int CHANNELS      = wrap_counter_pkg::DEFAULT_CHANNELS,
  parameter int DEFAULT_LIMIT = wrap_counter_pkg::DEFAULT_LIMIT
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [CHANNELS-1:0]                                 en,
  input  logic [CHANNELS-1:0]                                 dir,
  input  logic [CHANNELS-1:0]                                 sat_mode,
  input  logic                                                cfg_valid,
  output logic                                                cfg_ready,
  input  logic [wrap_counter_pkg::chan_sel_w(CHANNELS)-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]                                    cfg_limit,
  output logic [CHANNELS*WIDTH-1:0]                           count,
  output logic [CHANNELS*WIDTH-1:0]                           limit,
  output logic [CHANNELS-1:0]                                 wrap_pulse,
  output logic                                                inv_err
);

  import wrap_counter_pkg::*;

  localparam int CHAN_W = chan_sel_w(CHANNELS);

  cfg_state_e          state;
  cfg_state_e          state_nxt;
  logic [CHAN_W-1:0]   cap_chan;
  logic [WIDTH-1:0]    cap_limit;
  logic [CHANNELS-1:0] wr_en;
  logic [CHANNELS-1:0] over;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_valid) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE);
  end

  // NOTE: capture registers carry no reset; they are only read in APPLY, which is reached solely through a capture.
  always_ff @(posedge clk) begin
    if (state == IDLE && cfg_valid) begin
      cap_chan  <= cfg_chan;
      cap_limit <= cfg_limit;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    // Out-of-range captured channels match no index and are silently dropped.
    assign wr_en[i] = (state == APPLY) && (cap_chan == CHAN_W'(i));

    wrap_counter_chan #(
      .WIDTH       (WIDTH),
      .RESET_LIMIT (DEFAULT_LIMIT)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en         (en[i]),
      .dir        (dir[i]),
      .sat_mode   (sat_mode[i]),
      .wr_en      (wr_en[i]),
      .wr_limit   (cap_limit),
      .count      (count[i*WIDTH +: WIDTH]),
      .limit      (limit[i*WIDTH +: WIDTH]),
      .wrap_pulse (wrap_pulse[i])
    );

    assign over[i] = count[i*WIDTH +: WIDTH] > limit[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst)        inv_err <= 1'b0;
    else if (|over) inv_err <= 1'b1;
  end

endmodule

// File: tb/tb_wrap_counter_bank.sv
// Randomised and directed check of wrap_counter_bank against a cycle-level
// behavioural model of counts, limits, pulses and the config handshake.
module tb_wrap_counter_bank;
  import wrap_counter_pkg::*;

  localparam int W    = 10;
  localparam int N    = 4;
  localparam int LIM0 = 500;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  en, dir, sat_mode;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [W-1:0]  cfg_limit;
  logic [N*W-1:0] count, limit;
  logic [N-1:0]  wrap_pulse;
  logic          inv_err;

  always #5 clk = ~clk;

  wrap_counter_bank #(.WIDTH(W), .CHANNELS(N), .DEFAULT_LIMIT(LIM0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dir        (dir),
    .sat_mode   (sat_mode),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_limit  (cfg_limit),
    .count      (count),
    .limit      (limit),
    .wrap_pulse (wrap_pulse),
    .inv_err    (inv_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_cnt [N];
  int m_lim [N];
  bit m_pulse [N];
  bit m_pend;
  int m_cap_ch;
  int m_cap_lim;
  bit m_inv;
  int pulse_tally [N];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int cnt_of(int i);
    return int'(count[i*W +: W]);
  endfunction

  function automatic int lim_of(int i);
    return int'(limit[i*W +: W]);
  endfunction

  // Reference: one clock edge of the whole bank, from the current inputs.
  task automatic model_edge();
    bit ap;
    int ach, alim;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_lim[i] = LIM0; m_pulse[i] = 1'b0;
      end
      m_pend = 1'b0;
      m_inv  = 1'b0;
    end else begin
      ap = m_pend; ach = m_cap_ch; alim = m_cap_lim;
      for (int i = 0; i < N; i++) if (m_cnt[i] > m_lim[i]) m_inv = 1'b1;
      for (int i = 0; i < N; i++) begin
        m_pulse[i] = 1'b0;
        if (ap && ach == i) begin
          m_lim[i] = alim;
          if (m_cnt[i] > alim) m_cnt[i] = alim;
        end else if (en[i]) begin
          if (dir[i] == DIR_UP) begin
            if (m_cnt[i] < m_lim[i]) m_cnt[i] = m_cnt[i] + 1;
            else begin
              m_pulse[i] = 1'b1;
              if (sat_mode[i] != MODE_SAT) m_cnt[i] = (m_lim[i] == 0) ? 0 : 1;
            end
          end else begin
            if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            else begin
              m_pulse[i] = 1'b1;
              if (sat_mode[i] != MODE_SAT) m_cnt[i] = m_lim[i];
            end
          end
        end
      end
      if (m_pend) m_pend = 1'b0;
      else if (cfg_valid) begin
        m_pend = 1'b1; m_cap_ch = int'(cfg_chan); m_cap_lim = int'(cfg_limit);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("count%0d", i), cnt_of(i), m_cnt[i]);
      check($sformatf("limit%0d", i), lim_of(i), m_lim[i]);
      check($sformatf("pulse%0d", i), int'(wrap_pulse[i]), int'(m_pulse[i]));
      pulse_tally[i] += int'(wrap_pulse[i]);
    end
    check("cfg_ready", int'(cfg_ready), int'(!m_pend));
    check("inv_err", int'(inv_err), int'(m_inv));
  endtask

  task automatic idle_inputs();
    en = '0; dir = '0; sat_mode = '0;
    cfg_valid = 1'b0; cfg_chan = '0; cfg_limit = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) pulse_tally[i] = 0;
  endtask

  task automatic cfg_write(input int ch, input int lim);
    cfg_valid = 1'b1; cfg_chan = CW'(ch); cfg_limit = W'(lim);
    step();
    cfg_valid = 1'b0;
    check("ready_after_hs", int'(cfg_ready), 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_lim[i] = 0; m_pulse[i] = 1'b0; pulse_tally[i] = 0;
    end
    m_pend = 1'b0; m_cap_ch = 0; m_cap_lim = 0; m_inv = 1'b0;
    idle_inputs();
    rst = 1'b1;

    // Reset state
    do_reset();
    check("rst_ready", int'(cfg_ready), 1);
    check("rst_limit0", lim_of(0), LIM0);

    // ch0 up-wrap through its limit
    en[0] = 1'b1;
    for (int c = 0; c < 501; c++) step();
    check("wrap_cnt0", cnt_of(0), 1);
    check("wrap_tally0", pulse_tally[0], 1);

    // ch1 saturating up
    do_reset();
    en[1] = 1'b1; sat_mode[1] = MODE_SAT;
    for (int c = 0; c < 600; c++) step();
    check("sat_cnt1", cnt_of(1), LIM0);
    check("sat_tally1", pulse_tally[1], 100);

    // ch2 down from zero: wrap, then saturate
    do_reset();
    en[2] = 1'b1; dir[2] = DIR_DOWN;
    step();
    check("dnwrap_cnt2", cnt_of(2), LIM0);
    step();
    check("dnwrap_cnt2b", cnt_of(2), LIM0 - 1);
    do_reset();
    en[2] = 1'b1; dir[2] = DIR_DOWN; sat_mode[2] = MODE_SAT;
    for (int c = 0; c < 3; c++) step();
    check("dnsat_cnt2", cnt_of(2), 0);
    check("dnsat_tally2", pulse_tally[2], 3);

    // ch3 clamp on a lower limit
    do_reset();
    en[3] = 1'b1;
    for (int c = 0; c < 300; c++) step();
    en[3] = 1'b0;
    check("pre_cfg_cnt3", cnt_of(3), 300);
    cfg_write(3, 100);
    check("clamp_lim3", lim_of(3), 100);
    check("clamp_cnt3", cnt_of(3), 100);
    check("ready_back", int'(cfg_ready), 1);

    // limit 0 on ch0, then an out-of-range target
    cfg_write(0, 0);
    en[0] = 1'b1;
    for (int i = 0; i < N; i++) pulse_tally[i] = 0;
    for (int c = 0; c < 5; c++) step();
    check("lim0_cnt0", cnt_of(0), 0);
    check("lim0_tally0", pulse_tally[0], 5);
    en[0] = 1'b0;
    cfg_write(7, 33);
    check("oor_lim1", lim_of(1), LIM0);
    check("oor_lim3", lim_of(3), 100);

    // reset while a request sits in APPLY
    cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_limit = 10'd50;
    step();
    cfg_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_apply_lim1", lim_of(1), LIM0);
    check("rst_apply_lim3", lim_of(3), LIM0);
    step();
    check("rst_apply_lim1b", lim_of(1), LIM0);

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      en        = N'($urandom);
      dir       = N'($urandom);
      sat_mode  = N'($urandom);
      cfg_valid = ($urandom_range(0, 19) == 0);
      cfg_chan  = CW'($urandom_range(0, 7));
      cfg_limit = W'($urandom_range(0, 1023));
      rst       = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    check("inv_err_final", int'(inv_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
